// File: rtl/cdc_pkg.sv
// Shared definitions for the 4-phase handshake blocks (tx now, rx later).
//   hs_state_t           : handshake FSM state encoding
//   phase_cnt_width(t)   : phase counter width able to hold the value t
package cdc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        REQ_LO = 2'd2
    } hs_state_t;

    // A zero timeout still needs a 1-bit counter so the port widths stay legal.
    function automatic int phase_cnt_width(input int t);
        return (t > 0) ? $clog2(t + 1) : 1;
    endfunction

endpackage

// File: rtl/synchronizer.sv
// Two-flop synchronizer for signals entering the clk domain.
//   clk : destination clock
//   d   : asynchronous input
//   q   : synchronized output, two cycles of latency
// The flops are intentionally not reset; they flush within two cycles.
module synchronizer #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        meta <= d;
        q    <= meta;
    end

endmodule

// File: rtl/cdc_handshake_tx.sv
// Transmit side of a 4-phase request/acknowledge clock-domain crossing.
//   clk, rst        : clock and synchronous active-high reset
//   in_data/valid   : local payload offer
//   in_ready        : block can accept (transfer on in_valid && in_ready)
//   xfer_req/data   : registered request and payload towards the remote domain
//   xfer_ack_async  : remote acknowledge, unsynchronized
//   busy            : handshake in progress
//   timeout_err     : sticky, a handshake phase overran TIMEOUT_CYCLES
//
// state  | meaning
// IDLE   | waiting for a local offer
// REQ_HI | request raised, waiting for ack to rise
// REQ_LO | request dropped, waiting for ack to fall
module cdc_handshake_tx
    import cdc_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             xfer_req,
    output logic [WIDTH-1:0] xfer_data,
    input  logic             xfer_ack_async,
    output logic             busy,
    output logic             timeout_err
);

    localparam int             CW       = phase_cnt_width(TIMEOUT_CYCLES);
    localparam bit             TO_EN    = (TIMEOUT_CYCLES > 0);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    hs_state_t     state;
    logic          ack_s;
    logic [CW-1:0] phase_cnt;
    logic [CW-1:0] phase_cnt_inc;
    logic          phase_expired;
    logic [1:0]    settle_cnt;

    synchronizer #(.WIDTH(1)) u_ack_sync (
        .clk (clk),
        .d   (xfer_ack_async),
        .q   (ack_s)
    );

    // The cycle that makes the count reach TIMEOUT_CYCLES is the expiring one,
    // so a phase lasts at most TIMEOUT_CYCLES cycles.
    assign phase_expired = TO_EN && (phase_cnt == CNT_LAST);
    // Saturate so a stuck REQ_LO never wraps and re-arms.
    assign phase_cnt_inc = (phase_cnt == CNT_MAX) ? phase_cnt : phase_cnt + CW'(1);

    assign in_ready = (state == IDLE) && !ack_s && (settle_cnt == 2'd2);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            xfer_req    <= 1'b0;
            xfer_data   <= '0;
            timeout_err <= 1'b0;
            phase_cnt   <= '0;
            settle_cnt  <= 2'd0;
        end else begin
            if (settle_cnt != 2'd2) begin
                settle_cnt <= settle_cnt + 2'd1;
            end
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        xfer_data <= in_data;
                        xfer_req  <= 1'b1;
                        state     <= REQ_HI;
                        phase_cnt <= '0;
                    end
                end
                REQ_HI: begin
                    if (ack_s) begin
                        xfer_req  <= 1'b0;
                        state     <= REQ_LO;
                        phase_cnt <= '0;
                    end else if (phase_expired) begin
                        // Withdraw the request; the remote may still ack late.
                        timeout_err <= 1'b1;
                        xfer_req    <= 1'b0;
                        state       <= REQ_LO;
                        phase_cnt   <= '0;
                    end else begin
                        phase_cnt <= phase_cnt_inc;
                    end
                end
                REQ_LO: begin
                    if (!ack_s) begin
                        state     <= IDLE;
                        phase_cnt <= '0;
                    end else begin
                        // Never leave with ack high: the next request would be
                        // indistinguishable from the stale acknowledge.
                        if (phase_expired) begin
                            timeout_err <= 1'b1;
                        end
                        phase_cnt <= phase_cnt_inc;
                    end
                end
                default: begin
                    state     <= IDLE;
                    xfer_req  <= 1'b0;
                    phase_cnt <= '0;
                end
            endcase
        end
    end

endmodule
